// File: rtl/led_pkg.sv
// Shared types, frame counts and pattern decode for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BINARY = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam int unsigned FRAMES_CHASE  = 4;
    localparam int unsigned FRAMES_BOUNCE = 6;
    localparam int unsigned FRAMES_BLINK  = 2;
    localparam int unsigned FRAMES_BINARY = 16;
    localparam int unsigned FRAME_W       = 4;

    // Index of the final frame before the pattern wraps to frame 0.
    function automatic logic [FRAME_W-1:0] last_frame(input mode_e mode);
        logic [FRAME_W-1:0] last;
        last = '0;
        case (mode)
            MODE_CHASE:  last = FRAME_W'(FRAMES_CHASE - 1);
            MODE_BOUNCE: last = FRAME_W'(FRAMES_BOUNCE - 1);
            MODE_BLINK:  last = FRAME_W'(FRAMES_BLINK - 1);
            MODE_BINARY: last = FRAME_W'(FRAMES_BINARY - 1);
            default:     last = '0;
        endcase
        return last;
    endfunction

    function automatic logic [3:0] frame_leds(input mode_e mode, input logic [FRAME_W-1:0] f);
        logic [3:0] leds;
        leds = 4'b0000;
        case (mode)
            MODE_CHASE:  leds = 4'b0001 << f[1:0];
            MODE_BOUNCE: begin
                case (f)
                    4'd0:    leds = 4'b0001;
                    4'd1:    leds = 4'b0010;
                    4'd2:    leds = 4'b0100;
                    4'd3:    leds = 4'b1000;
                    4'd4:    leds = 4'b0100;
                    4'd5:    leds = 4'b0010;
                    default: leds = 4'b0000;
                endcase
            end
            MODE_BLINK:  leds = f[0] ? 4'b0000 : 4'b1111;
            MODE_BINARY: leds = f;
            default:     leds = 4'b0000;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Step prescaler: period is TICK_DIV >> speed; tick marks the last count of each period.
module tick_gen #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_last;

    assign period_last = (CNT_W'(TICK_DIV) >> speed) - CNT_W'(1);
    assign tick        = run && (count == period_last);

    // Holds whenever neither running nor cleared (paused).
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer with config handshake applied on step boundaries.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned CNT_W    = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pause,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_mode,
    input  logic [1:0] cfg_speed,
    output logic [3:0] led,
    output logic       frame_done
);

    state_e             state;
    mode_e              mode;
    mode_e              pend_mode;
    mode_e              idle_mode_c;
    logic [1:0]         speed;
    logic [1:0]         pend_speed;
    logic               pend_valid;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] frame_nxt_c;
    logic               wrap_c;
    logic               run_c;
    logic               clr_c;
    logic               cfg_xfer_c;
    logic               tick;

    // Prescaler counts only in RUN with no pause/disable request pending this cycle.
    assign run_c       = (state == ST_RUN) && enable && !pause;
    assign clr_c       = (state == ST_IDLE) || !enable;
    assign cfg_xfer_c  = cfg_valid && cfg_ready;
    assign wrap_c      = (frame == last_frame(mode));
    assign frame_nxt_c = wrap_c ? '0 : frame + FRAME_W'(1);
    assign idle_mode_c = pend_valid ? pend_mode : mode;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run_c),
        .clr   (clr_c),
        .speed (speed),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mode       <= MODE_CHASE;
            speed      <= '0;
            frame      <= '0;
            led        <= '0;
            frame_done <= 1'b0;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_CHASE;
            pend_speed <= '0;
            cfg_ready  <= 1'b1;
        end else begin
            frame_done <= 1'b0;

            // cfg_ready is low whenever a config is pending, so capture and apply never collide.
            if (cfg_xfer_c) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_e'(cfg_mode);
                pend_speed <= cfg_speed;
                cfg_ready  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        mode       <= pend_mode;
                        speed      <= pend_speed;
                        pend_valid <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end
                    if (enable) begin
                        state <= ST_RUN;
                        frame <= '0;
                        led   <= frame_leds(idle_mode_c, FRAME_W'(0));
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        frame <= '0;
                        led   <= '0;
                    end else if (pause) begin
                        state <= ST_PAUSED;
                    end else if (tick) begin
                        if (pend_valid) begin
                            mode       <= pend_mode;
                            speed      <= pend_speed;
                            pend_valid <= 1'b0;
                            cfg_ready  <= 1'b1;
                            frame      <= '0;
                            led        <= frame_leds(pend_mode, FRAME_W'(0));
                        end else begin
                            frame      <= frame_nxt_c;
                            led        <= frame_leds(mode, frame_nxt_c);
                            frame_done <= wrap_c;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        frame <= '0;
                        led   <= '0;
                    end else if (!pause) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scenario bench for led_pattern_ctrl with TICK_DIV=8; expected frames queued per cycle.
module tb_led_pattern_ctrl;

    localparam int unsigned TICK_DIV = 8;
    localparam int unsigned CNT_W    = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pause;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [1:0] cfg_speed;
    logic [3:0] led;
    logic       frame_done;

    typedef struct {
        logic [3:0] led;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] chase_tbl  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] bounce_tbl [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pause      (pause),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_speed  (cfg_speed),
        .led        (led),
        .frame_done (frame_done)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] l, input logic fd, input logic rdy);
        exp_t e;
        e.led = l;
        e.fd  = fd;
        e.rdy = rdy;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        reset     = 1'b1;
        enable    = 1'b0;
        pause     = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode  = 2'd0;
        cfg_speed = 2'd0;
        for (int i = 0; i < 3; i++) push_exp(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            if (i == 1) reset = 1'b0;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL reset cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         i, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_chase();
        exp_t e;
        int   k;
        for (int i = 1; i <= 36; i++) begin
            k = (i - 1) / 8;
            push_exp(chase_tbl[k % 4], (i > 1) && ((i - 1) % 8 == 0) && (k % 4 == 0), 1'b1);
        end
        enable = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            tick_clk();
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL chase cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         i, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_cfg_bounce();
        exp_t e;
        int   k;
        for (int i = 1; i <= 30; i++) begin
            if (i <= 4) begin
                push_exp(4'b0001, 1'b0, 1'b0);
            end else begin
                k = (i - 5) / 2;
                push_exp(bounce_tbl[k % 6], (i > 5) && ((i - 5) % 2 == 0) && (k % 6 == 0), 1'b1);
            end
        end
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        cfg_speed = 2'd2;
        for (int i = 1; i <= 30; i++) begin
            tick_clk();
            if (i == 1) cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL cfg_bounce cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         i, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_pause_binary();
        exp_t e;
        for (int g = 1; g <= 48; g++) begin
            if (g <= 2)       push_exp(4'b0010, 1'b0, 1'b0);
            else if (g <= 25) push_exp(4'((g - 3) / 4), 1'b0, 1'b1);
            else if (g < 48)  push_exp(4'b0101, 1'b0, 1'b1);
            else              push_exp(4'b0110, 1'b0, 1'b1);
        end
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_speed = 2'd1;
        for (int g = 1; g <= 48; g++) begin
            tick_clk();
            if (g == 1)  cfg_valid = 1'b0;
            if (g == 25) pause = 1'b1;
            if (g == 45) pause = 1'b0;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL pause_binary cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         g, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_enable_fall_on_tick();
        exp_t e;
        push_exp(4'b0110, 1'b0, 1'b1);
        push_exp(4'b0110, 1'b0, 1'b0);
        push_exp(4'b0110, 1'b0, 1'b0);
        push_exp(4'b0000, 1'b0, 1'b0);
        push_exp(4'b0000, 1'b0, 1'b1);
        for (int n = 6; n <= 14; n++) push_exp(chase_tbl[((n - 6) / 8) % 4], 1'b0, 1'b1);
        for (int n = 1; n <= 14; n++) begin
            tick_clk();
            if (n == 1) begin
                cfg_valid = 1'b1;
                cfg_mode  = 2'd0;
                cfg_speed = 2'd0;
            end
            if (n == 2) cfg_valid = 1'b0;
            if (n == 3) enable = 1'b0;
            if (n == 5) enable = 1'b1;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL enable_fall cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         n, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_cfg_hold();
        exp_t e;
        for (int j = 1; j <= 7; j++) push_exp(4'b0010, 1'b0, 1'b0);
        push_exp(4'b1111, 1'b0, 1'b1);
        push_exp(4'b0000, 1'b0, 1'b0);
        for (int j = 10; j <= 27; j++) push_exp(4'((j - 10) % 16), (j == 26), 1'b1);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd2;
        cfg_speed = 2'd3;
        for (int j = 1; j <= 27; j++) begin
            tick_clk();
            if (j == 1) cfg_mode = 2'd3;
            if (j == 9) cfg_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL cfg_hold cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         j, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t e;
        int   k;
        push_exp(4'b0010, 1'b0, 1'b0);
        push_exp(4'b0000, 1'b0, 1'b1);
        for (int r = 3; r <= 35; r++) begin
            k = (r - 3) / 8;
            push_exp(chase_tbl[k % 4], (r == 35), 1'b1);
        end
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        cfg_speed = 2'd0;
        for (int r = 1; r <= 35; r++) begin
            tick_clk();
            if (r == 1) begin
                cfg_valid = 1'b0;
                reset     = 1'b1;
            end
            if (r == 2) reset = 1'b0;
            e = sb.pop_front();
            checks++;
            if (led !== e.led || frame_done !== e.fd || cfg_ready !== e.rdy) begin
                failures++;
                $display("FAIL reset_pending cyc=%0d led/fd/rdy got=%b/%b/%b exp=%b/%b/%b",
                         r, led, frame_done, cfg_ready, e.led, e.fd, e.rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_chase();
        test_cfg_bounce();
        test_pause_binary();
        test_enable_fall_on_tick();
        test_cfg_hold();
        test_reset_pending();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
